// File: rtl/display_scan_reader.sv
// rtl/display_scan_reader.sv - text RAM reader: per-scanline character fetch with latency-absorbing skid FIFO
module display_scan_reader #(
  parameter int COLS          = 64,
  parameter int ROWS          = 16,
  parameter int LINES_PER_ROW = 12,
  parameter int FIFO_DEPTH    = 4,
  parameter int RD_LAT        = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  frame_start,
  input  logic                                  line_start,
  output logic [$clog2(ROWS)+$clog2(COLS)-1:0]  ram_adb,
  output logic                                  ram_ceb,
  output logic                                  ram_oceb,
  input  logic [7:0]                            ram_doutb,
  output logic                                  char_valid,
  input  logic                                  char_ready,
  output logic [7:0]                            char_data,
  output logic [$clog2(COLS)-1:0]               char_col,
  output logic [$clog2(ROWS)-1:0]               char_row,
  output logic [$clog2(LINES_PER_ROW)-1:0]      char_line,
  output logic                                  char_last,
  output logic                                  busy,
  output logic                                  overrun
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int LW = $clog2(LINES_PER_ROW);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_FRAME_END} state_t;

  state_t          state;
  logic [RW-1:0]   row;
  logic [LW-1:0]   line;
  logic [CW-1:0]   col;
  logic [CW-1:0]   push_col;
  logic [RD_LAT-1:0] vs;
  logic [7:0]      fifo_data [FIFO_DEPTH];
  logic [CW-1:0]   fifo_col  [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     fifo_count;
  logic            push, pop, last_pop, issue;
  int              occ;

  assign push       = vs[RD_LAT-1];
  assign char_valid = (fifo_count != '0);
  assign pop        = char_valid && char_ready;
  assign last_pop   = pop && (fifo_col[rd_ptr] == CW'(COLS-1));
  assign char_data  = char_valid ? fifo_data[rd_ptr] : '0;
  assign char_col   = char_valid ? fifo_col[rd_ptr] : '0;
  assign char_last  = last_pop || (char_valid && fifo_col[rd_ptr] == CW'(COLS-1));
  assign char_row   = row;
  assign char_line  = line;

  // Credits: the issued-but-not-sampled read, the RAM pipeline and the FIFO share
  // FIFO_DEPTH slots; a pop in this cycle frees its slot for the next issue.
  always_comb begin
    occ   = int'(fifo_count) + $countones({ram_ceb, vs}) - int'(pop);
    issue = (state == S_FETCH) && (occ < FIFO_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      row        <= '0;
      line       <= '0;
      col        <= '0;
      push_col   <= '0;
      vs         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ram_adb    <= '0;
      ram_ceb    <= 1'b0;
      ram_oceb   <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      ram_oceb <= 1'b1;
      ram_ceb  <= issue;
      overrun  <= 1'b0;
      vs       <= (vs << 1) | RD_LAT'(ram_ceb);

      if (push) begin
        fifo_data[wr_ptr] <= ram_doutb;
        fifo_col[wr_ptr]  <= push_col;
        wr_ptr            <= wr_ptr + 1'b1;
        push_col          <= push_col + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + (PW+1)'(push) - (PW+1)'(pop);

      if (issue) begin
        ram_adb <= {row, col};
        col     <= col + 1'b1;
        if (col == CW'(COLS-1)) state <= S_DRAIN;
      end

      if (last_pop) begin
        busy <= 1'b0;
        if (line == LW'(LINES_PER_ROW-1)) begin
          line <= '0;
          row  <= row + 1'b1;
        end else begin
          line <= line + 1'b1;
        end
        state <= (row == RW'(ROWS-1) && line == LW'(LINES_PER_ROW-1)) ? S_FRAME_END : S_IDLE;
      end

      if (line_start) begin
        if (state == S_IDLE) begin
          state    <= S_FETCH;
          busy     <= 1'b1;
          col      <= '0;
          push_col <= '0;
        end else begin
          overrun  <= 1'b1;
        end
      end

      // Frame restart wins over everything above; a coincident line_start then begins row 0.
      if (frame_start) begin
        state      <= line_start ? S_FETCH : S_IDLE;
        busy       <= line_start;
        overrun    <= 1'b0;
        row        <= '0;
        line       <= '0;
        col        <= '0;
        push_col   <= '0;
        vs         <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        ram_adb    <= '0;
        ram_ceb    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_display_scan_reader.sv
// tb/tb_display_scan_reader.sv - directed bench for display_scan_reader with a 2-clock pipelined RAM model
module tb_display_scan_reader;
  logic       clk = 1'b0;
  logic       reset, frame_start, line_start, char_ready;
  logic [9:0] ram_adb;
  logic       ram_ceb, ram_oceb;
  logic [7:0] ram_doutb;
  logic       char_valid, char_last, busy, overrun;
  logic [7:0] char_data;
  logic [5:0] char_col;
  logic [3:0] char_row, char_line;

  int total = 0;
  int bad   = 0;
  int ready_mode = 0;

  logic [7:0] tb_mem [1024];
  logic [9:0] ram_addr_q;

  logic [7:0] rx_data [$];
  logic [5:0] rx_col  [$];
  logic [3:0] rx_row  [$];
  logic [3:0] rx_line [$];
  logic       rx_last [$];
  logic [9:0] adr_q   [$];
  int issued = 0, accepted = 0, occ = 0, ceb_total = 0, valid_total = 0;
  int hold_checks = 0, hold_bad = 0;
  logic        prev_hold = 1'b0;
  logic [22:0] prev_out = '0;

  display_scan_reader dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
    .ram_adb(ram_adb), .ram_ceb(ram_ceb), .ram_oceb(ram_oceb), .ram_doutb(ram_doutb),
    .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data),
    .char_col(char_col), .char_row(char_row), .char_line(char_line),
    .char_last(char_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Address register on ceb, output register on oceb: data usable two edges after issue.
  always @(posedge clk) begin
    if (ram_ceb) ram_addr_q <= ram_adb;
    if (ram_oceb) ram_doutb <= tb_mem[ram_addr_q];
  end

  always @(negedge clk) begin
    if (reset || frame_start) begin
      issued   = 0;
      accepted = 0;
    end else begin
      occ = issued - accepted;
      if (ram_ceb) begin
        issued++;
        adr_q.push_back(ram_adb);
      end
      if (char_valid && char_ready) begin
        accepted++;
        rx_data.push_back(char_data);
        rx_col.push_back(char_col);
        rx_row.push_back(char_row);
        rx_line.push_back(char_line);
        rx_last.push_back(char_last);
      end
    end
    if (ram_ceb) ceb_total++;
    if (char_valid) valid_total++;
    if (prev_hold) begin
      hold_checks++;
      if ({char_valid, char_data, char_col, char_row, char_line, char_last} !== {1'b1, prev_out}) hold_bad++;
    end
    prev_hold = char_valid && !char_ready && !reset && !frame_start;
    prev_out  = {char_data, char_col, char_row, char_line, char_last};
  end

  initial begin
    int stall_left;
    stall_left = 0;
    char_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: char_ready = 1'b1;
        1: char_ready = !char_ready;
        2: begin
          if (stall_left > 0) begin
            char_ready = 1'b0;
            stall_left--;
          end else if ($urandom_range(0, 3) == 0) begin
            stall_left = $urandom_range(0, 9);
            char_ready = 1'b0;
          end else begin
            char_ready = 1'b1;
          end
        end
        default: char_ready = 1'b0;
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic verify_line(input int base, input int abase, input logic [3:0] er,
                             input logic [3:0] el, input int max_occ);
    int errs;
    logic [9:0] a;
    check("char_count", rx_data.size() - base, 64);
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      if (base + i < rx_data.size()) begin
        a = {er, 6'(i)};
        if (rx_data[base+i] !== tb_mem[a] || rx_col[base+i] !== 6'(i) || rx_row[base+i] !== er ||
            rx_line[base+i] !== el || rx_last[base+i] !== (i == 63)) errs++;
      end
    end
    check("char_order", errs, 0);
    check("first_adr", (adr_q.size() > abase) ? 32'(adr_q[abase]) : 32'hFFFF_FFFF, 32'({er, 6'd0}));
    check("fifo_bound", 32'(max_occ <= 4), 1);
  endtask

  task automatic run_line(input logic [3:0] er, input logic [3:0] el, input int ovr_at);
    int base, abase, max_occ;
    base = rx_data.size();
    abase = adr_q.size();
    max_occ = 0;
    line_start = 1'b1;
    tick(1);
    line_start = 1'b0;
    if (ovr_at > 0) begin
      tick(ovr_at - 1);
      line_start = 1'b1;
      tick(1);
      line_start = 1'b0;
      check("overrun_pulse", overrun, 1);
      tick(1);
      check("overrun_clear", overrun, 0);
    end
    for (int i = 0; i < 4000 && busy; i++) begin
      tick(1);
      if (occ > max_occ) max_occ = occ;
    end
    check("line_done", busy, 0);
    verify_line(base, abase, er, el, max_occ);
    tick(2);
  endtask

  initial begin
    int base, abase, vt, cb;
    for (int i = 0; i < 1024; i++) tb_mem[i] = 8'h20;
    tb_mem[0]  = 8'h41;
    tb_mem[63] = 8'h5A;
    for (int c = 0; c < 64; c++) tb_mem[64+c] = 8'h80 + 8'(c);
    reset = 1'b1; frame_start = 1'b0; line_start = 1'b0;
    tick(3);
    check("rst_valid_busy_ceb", {char_valid, busy, ram_ceb, overrun, char_last}, 0);
    check("rst_oceb", ram_oceb, 0);
    check("rst_data", {ram_adb, char_data, char_col, char_row, char_line}, 0);
    reset = 1'b0;
    tick(1);
    check("oceb_after_reset", ram_oceb, 1);
    frame_start = 1'b1; tick(1); frame_start = 1'b0; tick(1);

    base = rx_data.size(); abase = adr_q.size();
    line_start = 1'b1; tick(1); line_start = 1'b0;
    check("n0_busy", busy, 1);
    check("n0_ceb", ram_ceb, 0);
    tick(1);
    check("n1_ceb", ram_ceb, 1);
    check("n1_adb", ram_adb, 10'h000);
    tick(2);
    check("n3_valid", char_valid, 0);
    tick(1);
    check("n4_valid", char_valid, 1);
    check("n4_data", char_data, 8'h41);
    tick(63);
    check("n67_busy", busy, 1);
    check("n67_last", {char_last, char_data, char_col}, {1'b1, 8'h5A, 6'd63});
    tick(1);
    check("n68_busy", busy, 0);
    check("n68_valid", char_valid, 0);
    verify_line(base, abase, 4'd0, 4'd0, 0);
    tick(2);

    for (int l = 1; l < 12; l++) run_line(4'd0, 4'(l), 0);
    run_line(4'd1, 4'd0, 0);
    ready_mode = 1;
    run_line(4'd1, 4'd1, 0);
    ready_mode = 2;
    run_line(4'd1, 4'd2, 0);
    ready_mode = 0;
    run_line(4'd1, 4'd3, 10);
    for (int k = 16; k < 192; k++) run_line(4'(k / 12), 4'(k % 12), 0);

    cb = ceb_total;
    line_start = 1'b1; tick(1); line_start = 1'b0;
    check("frame_end_overrun", overrun, 1);
    tick(10);
    check("frame_end_no_ceb", ceb_total - cb, 0);
    check("frame_end_busy", busy, 0);

    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    run_line(4'd0, 4'd0, 0);

    line_start = 1'b1; tick(1); line_start = 1'b0;
    tick(65);
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    check("fs_drain_outputs", {char_valid, busy, ram_ceb, overrun, char_data, char_col, char_row, char_line, char_last}, 0);
    vt = valid_total;
    tick(10);
    check("fs_drain_no_stale", valid_total - vt, 0);

    line_start = 1'b1; tick(1); line_start = 1'b0;
    tick(9);
    reset = 1'b1; tick(1);
    check("rst_fetch_outputs", {char_valid, busy, ram_ceb, ram_oceb, overrun, char_last}, 0);
    check("rst_fetch_data", {ram_adb, char_data, char_col, char_row, char_line}, 0);
    reset = 1'b0;
    vt = valid_total; cb = ceb_total;
    tick(10);
    check("rst_fetch_no_stale", valid_total - vt, 0);
    check("rst_fetch_no_ceb", ceb_total - cb, 0);
    run_line(4'd0, 4'd0, 0);

    check("hold_seen", 32'(hold_checks > 0), 1);
    check("hold_stable", hold_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
